seq_detector_param: RTL
=======================

# seq_detector_param

Parametrised serial pattern detector: the successor to the fixed 1010 Moore detector. The pattern (up to MAX_LEN bits) and its active length are loadable at run time, with a runtime overlap / non-overlap mode, a valid qualifier on the serial input and a saturating match counter. It sits on a single-bit serial stream inside the FSM examples and can be reused as a generic framing / sync-word detector.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (2..32).
- DEF_PATTERN, 8'b0000_1010: pattern loaded at reset; the LSB is the last bit received.
- DEF_LEN, 4: active length loaded at reset.
- CNT_W, 8: match counter width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset; asserted when 0.
- a  in  1  serial data bit.
- a_valid  in  1  `a` is sampled only when this is 1.
- overlap  in  1  1 = overlapping matches allowed; 0 = history cleared after each match.
- cfg_load  in  1  load cfg_pattern / cfg_len on this edge.
- cfg_pattern  in  MAX_LEN  new pattern, right-aligned; the LSB is the last bit.
- cfg_len  in  $clog2(MAX_LEN+1)  new active length.
- cnt_clr  in  1  synchronous clear of match_count.
- y  out  1  registered one-cycle match pulse.
- match_count  out  CNT_W  saturating count of matches.

## Operation
- **State**
  - hist: MAX_LEN-bit shift register; a new bit enters at the LSB.
  - fill: count of valid bits held, saturating at MAX_LEN.
  - pat and len: the active configuration.
- **Accepted bit** (a_valid=1, cfg_load=0)
  - hist <= {hist[MAX_LEN-2:0], a}.
  - fill <= min(fill+1, MAX_LEN).
- **Match** is evaluated on the updated history: fill_next >= len and hist_next[len-1:0] == pat[len-1:0].
  - On a match, y <= 1 on the same edge.
  - If overlap=0, fill <= 0 on a match, so the next match needs len fresh bits. hist bits are kept but ignored.
  - If overlap=1, fill is untouched.
- **No accepted bit**: y <= 0. hist and fill hold.
- **cfg_load=1**
  - pat <= cfg_pattern; fill <= 0; y <= 0.
  - len <= cfg_len, except cfg_len = 0, 1 or > MAX_LEN, which loads MAX_LEN.
  - cfg_load takes priority over a simultaneous a_valid; that bit is discarded.
- **overlap** is sampled every edge. Changing it mid-stream only affects the next match.
- **match_count**
  - Increments on each match and saturates at 2^CNT_W-1.
  - cnt_clr=1 clears it to 0 and wins over a simultaneous match. y still pulses in that case.

## Timing
- Reset values: y=0, match_count=0, hist=0, fill=0, pat=DEF_PATTERN, len=DEF_LEN.
- Latency: y is high for exactly the one cycle following the clk edge that accepts the final pattern bit. This is Moore-style registered output; there is no combinational path from a to y.
- match_count updates on the same edge as y.
- Back-to-back matches are possible when overlap=1: for a period-p pattern, y can pulse every p accepted bits.
- a_valid gaps hold state; matching is over accepted bits only.
- Reset mid-stream immediately clears history and restores the default configuration. The first match after reset needs len bits.

## Structure
- Package seq_det_pkg holds:
  - LEN_W = $clog2(MAX_LEN+1);
  - function clamp_len(), implementing the cfg_len clamp rule;
  - function pat_mask(len), giving the low-len-bit mask used in the compare.
- One sub-module, sat_counter (parameters W; ports clk, rst, inc, clr, q), used for match_count.
- Detector core: hist/fill/config registers plus a masked-compare and y register. Target about 150 RTL lines.

## Test plan
- **Default 1010, overlap=1**: reset, then a = 1,1,1,0,1,0,1,0 with a_valid=1 throughout.
  - y pulses after the 6th and 8th bits.
  - match_count=2.
- **Same stream, overlap=0**: y pulses only after the 6th bit; match_count=1.
- **Reconfigure**: cfg_load with cfg_pattern=8'b1101_0011 and cfg_len=8; feed 1,1,0,1,0,0,1,1.
  - y pulses once after the 8th bit.
  - cfg_len=0 in a separate load yields len=8.
- **Valid gaps**: stream 1,0,1,0 with a_valid low for 3 cycles between each bit; y pulses once, after the final accepted 0.
- **Counter rules**:
  - CNT_W=2 with 5 matches gives match_count=3 (saturated).
  - cnt_clr asserted on a match edge gives match_count=0 while y=1.
- **Async reset mid-pattern**: after 1,0,1, pull rst low between edges.
  - Outputs clear immediately.
  - After release, a further 0 gives no match; the full 1,0,1,0 then matches.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared helpers for the parametrised serial pattern detector:
// the length clamp applied on configuration load and the compare mask.
package seq_det_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int LEN_W       = $clog2(DEF_MAX_LEN + 1);

    // Lengths of 0, 1 or beyond the history depth fall back to the full depth.
    function automatic int unsigned clamp_len(input int unsigned cfg_len,
                                              input int unsigned max_len);
        if ((cfg_len < 2) || (cfg_len > max_len))
            return max_len;
        return cfg_len;
    endfunction

    function automatic logic [31:0] pat_mask(input int unsigned len);
        if (len >= 32)
            return '1;
        return (32'd1 << len) - 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesised flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/seq_detector_param.sv
// Run-time loadable serial pattern detector with overlap control, input
// qualifier, registered match pulse and saturating match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN     = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_1010),
    parameter int                 DEF_LEN     = 4,
    parameter int                 CNT_W       = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           a,
    input  logic                           a_valid,
    input  logic                           overlap,
    input  logic                           cfg_load,
    input  logic [MAX_LEN-1:0]             cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
    input  logic                           cnt_clr,
    output logic                           y,
    output logic [CNT_W-1:0]               match_count
);

    localparam int LW = $clog2(MAX_LEN + 1);

    logic [MAX_LEN-1:0] r_hist;
    logic [LW-1:0]      r_fill;
    logic [MAX_LEN-1:0] r_pat;
    logic [LW-1:0]      r_len;
    logic               r_y;

    logic               w_accept;
    logic [MAX_LEN-1:0] w_hist_next;
    logic [LW-1:0]      w_fill_inc;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_match;

    // A configuration load owns the edge; a bit arriving with it is dropped.
    assign w_accept    = a_valid && !cfg_load;
    assign w_hist_next = {r_hist[MAX_LEN-2:0], a};
    assign w_fill_inc  = (r_fill == LW'(MAX_LEN)) ? r_fill : r_fill + LW'(1);
    assign w_mask      = MAX_LEN'(pat_mask(32'(r_len)));
    assign w_match     = w_accept && (w_fill_inc >= r_len) &&
                         (((w_hist_next ^ r_pat) & w_mask) == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hist <= '0;
            r_fill <= '0;
            r_pat  <= DEF_PATTERN;
            r_len  <= LW'(clamp_len(DEF_LEN, MAX_LEN));
            r_y    <= 1'b0;
        end else if (cfg_load) begin
            r_pat  <= cfg_pattern;
            r_len  <= LW'(clamp_len(32'(cfg_len), MAX_LEN));
            r_fill <= '0;
            r_y    <= 1'b0;
        end else if (w_accept) begin
            r_hist <= w_hist_next;
            // Non-overlap mode forgets the matched bits; stale hist is masked by fill.
            r_fill <= (w_match && !overlap) ? '0 : w_fill_inc;
            r_y    <= w_match;
        end else begin
            r_y    <= 1'b0;
        end
    end

    assign y = r_y;

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_match),
        .clr (cnt_clr),
        .q   (match_count)
    );

endmodule
